// File: rtl/hoplite_message_interface.sv
// Hoplite mesh endpoint for one PicoRV32 PE: stages PE message strobes into
// single-word flits (TX FIFO) and buffers router flits for the PE (RX FIFO).
module hoplite_message_interface #(
  parameter int COORD_BITS = 1,
  parameter int TX_DEPTH   = 4,
  parameter int RX_DEPTH   = 4,
  localparam int FLIT_W    = 33 + 2 * COORD_BITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [COORD_BITS-1:0] pe_x_coord,
  input  logic                  pe_x_coord_valid,
  input  logic [COORD_BITS-1:0] pe_y_coord,
  input  logic                  pe_y_coord_valid,
  input  logic [31:0]           pe_message,
  input  logic                  pe_message_valid,
  input  logic                  pe_packet_complete,
  output logic [31:0]           pe_message_in,
  output logic                  pe_message_in_valid,
  input  logic                  pe_message_in_read,
  input  logic                  pe_message_in_ready,
  output logic [FLIT_W-1:0]     tx_flit,
  output logic                  tx_flit_valid,
  input  logic                  tx_flit_ready,
  input  logic [FLIT_W-1:0]     rx_flit,
  input  logic                  rx_flit_valid,
  output logic                  rx_flit_ready,
  output logic                  tx_overflow,
  output logic                  proto_error
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_AW + 1;

  logic [COORD_BITS-1:0] dest_x, dest_y;
  logic                  stg_valid;
  logic [COORD_BITS-1:0] stg_x, stg_y;
  logic [31:0]           stg_data;

  logic [FLIT_W-1:0] tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]  tx_wr_ptr, tx_rd_ptr;
  logic [TX_CW-1:0]  tx_count;

  logic [31:0]      rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_CW-1:0] rx_count;
  logic             rx_en;

  logic              tx_pop, tx_push_req, tx_push, tx_full;
  logic [FLIT_W-1:0] tx_push_flit;
  logic              rx_push, rx_pop, rx_empty, proto_hit;
  logic              rx_flit_unused;

  // The staged word closes the packet only when no new message displaces it.
  assign tx_push_req  = stg_valid && (pe_message_valid || pe_packet_complete);
  assign tx_push_flit = {~pe_message_valid, stg_y, stg_x, stg_data};
  assign tx_full      = (tx_count == TX_CW'(TX_DEPTH));
  assign tx_pop       = tx_flit_valid && tx_flit_ready;
  assign tx_push      = tx_push_req && (!tx_full || tx_pop);

  assign tx_flit_valid = (tx_count != '0);
  assign tx_flit       = tx_flit_valid ? tx_mem[tx_rd_ptr] : '0;

  assign rx_empty            = (rx_count == '0);
  assign rx_flit_ready       = rx_en && (rx_count < RX_CW'(RX_DEPTH));
  assign rx_push             = rx_flit_valid && rx_flit_ready;
  assign rx_pop              = pe_message_in_read && !rx_empty;
  assign pe_message_in_valid = !rx_empty;
  assign pe_message_in       = rx_empty ? 32'h0 : rx_mem[rx_rd_ptr];
  assign rx_flit_unused      = ^rx_flit[FLIT_W-1:32];

  assign proto_hit = (pe_packet_complete && (!stg_valid || pe_message_valid))
                   || (pe_message_in_read && rx_empty);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_push_flit;
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_flit[31:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dest_x      <= '0;
      dest_y      <= '0;
      stg_valid   <= 1'b0;
      stg_x       <= '0;
      stg_y       <= '0;
      stg_data    <= '0;
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      tx_count    <= '0;
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      rx_en       <= 1'b0;
      tx_overflow <= 1'b0;
      proto_error <= 1'b0;
    end else begin
      if (pe_x_coord_valid) dest_x <= pe_x_coord;
      if (pe_y_coord_valid) dest_y <= pe_y_coord;

      if (pe_message_valid) begin
        stg_valid <= 1'b1;
        stg_x     <= dest_x;
        stg_y     <= dest_y;
        stg_data  <= pe_message;
      end else if (pe_packet_complete) begin
        stg_valid <= 1'b0;
      end

      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + TX_CW'(1);
        2'b01:   tx_count <= tx_count - TX_CW'(1);
        default: tx_count <= tx_count;
      endcase
      if (tx_push_req && !tx_push) tx_overflow <= 1'b1;

      if (pe_message_in_ready) rx_en <= 1'b1;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + RX_CW'(1);
        2'b01:   rx_count <= rx_count - RX_CW'(1);
        default: rx_count <= rx_count;
      endcase

      if (proto_hit) proto_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hoplite_message_interface.sv
// Directed bench for hoplite_message_interface: a per-cycle vector table for the
// basic TX packet and RX paths, plus hand sequences for overflow and reset cases.
module tb_hoplite_message_interface;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [0:0]  pe_x_coord, pe_y_coord;
  logic        pe_x_coord_valid, pe_y_coord_valid;
  logic [31:0] pe_message;
  logic        pe_message_valid, pe_packet_complete;
  logic [31:0] pe_message_in;
  logic        pe_message_in_valid, pe_message_in_read, pe_message_in_ready;
  logic [34:0] tx_flit, rx_flit;
  logic        tx_flit_valid, tx_flit_ready, rx_flit_valid, rx_flit_ready;
  logic        tx_overflow, proto_error;

  int n_checks = 0;
  int n_fail   = 0;

  hoplite_message_interface dut (
    .clk(clk), .reset_n(reset_n),
    .pe_x_coord(pe_x_coord), .pe_x_coord_valid(pe_x_coord_valid),
    .pe_y_coord(pe_y_coord), .pe_y_coord_valid(pe_y_coord_valid),
    .pe_message(pe_message), .pe_message_valid(pe_message_valid),
    .pe_packet_complete(pe_packet_complete),
    .pe_message_in(pe_message_in), .pe_message_in_valid(pe_message_in_valid),
    .pe_message_in_read(pe_message_in_read), .pe_message_in_ready(pe_message_in_ready),
    .tx_flit(tx_flit), .tx_flit_valid(tx_flit_valid), .tx_flit_ready(tx_flit_ready),
    .rx_flit(rx_flit), .rx_flit_valid(rx_flit_valid), .rx_flit_ready(rx_flit_ready),
    .tx_overflow(tx_overflow), .proto_error(proto_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        xv;  logic [0:0] x;  logic yv;  logic [0:0] y;
    logic        mv;  logic [31:0] m; logic cmp; logic trdy;
    logic        rv;  logic [34:0] rf; logic rd; logic irdy;
    logic        e_tv; logic [34:0] e_tf; logic e_rr; logic e_iv;
    logic [31:0] e_in; logic e_ovf; logic e_perr;
  } vec_t;

  vec_t vt [25];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_inputs();
    pe_x_coord = '0; pe_x_coord_valid = 0; pe_y_coord = '0; pe_y_coord_valid = 0;
    pe_message = '0; pe_message_valid = 0; pe_packet_complete = 0;
    pe_message_in_read = 0; pe_message_in_ready = 0;
    rx_flit = '0; rx_flit_valid = 0;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr_inputs();
    tx_flit_ready = 0;
    reset_n = 0;
    repeat (2) next();
    reset_n = 1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " tx_flit_valid"}, 64'(tx_flit_valid), 0);
    chk({tag, " tx_flit"}, 64'(tx_flit), 0);
    chk({tag, " rx_flit_ready"}, 64'(rx_flit_ready), 0);
    chk({tag, " pe_message_in_valid"}, 64'(pe_message_in_valid), 0);
    chk({tag, " pe_message_in"}, 64'(pe_message_in), 0);
    chk({tag, " tx_overflow"}, 64'(tx_overflow), 0);
    chk({tag, " proto_error"}, 64'(proto_error), 0);
  endtask

  initial begin
    logic [31:0] d;
    reset_n = 0;
    tx_flit_ready = 0;
    clr_inputs();

    //        xv x yv y mv m             cmp trdy rv rf            rd irdy | tv tf              rr iv in            ovf perr
    vt[0]  = '{1, 1, 1, 0, 0, 32'h0,        0, 1, 0, 35'h0,         0, 0,   0, 35'h0,          0, 0, 32'h0,        0, 0};
    vt[1]  = '{0, 0, 0, 0, 1, 32'hA5A50001, 0, 1, 0, 35'h0,         0, 0,   0, 35'h0,          0, 0, 32'h0,        0, 0};
    vt[2]  = '{0, 0, 0, 0, 1, 32'hA5A50002, 0, 1, 0, 35'h0,         0, 0,   0, 35'h0,          0, 0, 32'h0,        0, 0};
    vt[3]  = '{0, 0, 0, 0, 0, 32'h0,        1, 1, 0, 35'h0,         0, 0,   1, 35'h1A5A50001,  0, 0, 32'h0,        0, 0};
    vt[4]  = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 35'h0,         0, 0,   1, 35'h5A5A50002,  0, 0, 32'h0,        0, 0};
    vt[5]  = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 35'h0,         0, 0,   0, 35'h0,          0, 0, 32'h0,        0, 0};
    vt[6]  = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 35'h712345678, 0, 0,   0, 35'h0,          0, 0, 32'h0,        0, 0};
    vt[7]  = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 35'h712345678, 0, 1,   0, 35'h0,          0, 0, 32'h0,        0, 0};
    vt[8]  = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 35'h712345678, 0, 0,   0, 35'h0,          1, 0, 32'h0,        0, 0};
    vt[9]  = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 35'h0,         0, 0,   0, 35'h0,          1, 1, 32'h12345678, 0, 0};
    vt[10] = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 35'h0,         1, 0,   0, 35'h0,          1, 1, 32'h12345678, 0, 0};
    vt[11] = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 35'h0,         0, 0,   0, 35'h0,          1, 0, 32'h0,        0, 0};
    vt[12] = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 35'h10,        0, 0,   0, 35'h0,          1, 0, 32'h0,        0, 0};
    vt[13] = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 35'h11,        0, 0,   0, 35'h0,          1, 1, 32'h10,       0, 0};
    vt[14] = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 35'h12,        0, 0,   0, 35'h0,          1, 1, 32'h10,       0, 0};
    vt[15] = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 35'h13,        0, 0,   0, 35'h0,          1, 1, 32'h10,       0, 0};
    vt[16] = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 35'h99,        0, 0,   0, 35'h0,          0, 1, 32'h10,       0, 0};
    vt[17] = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 35'h0,         1, 0,   0, 35'h0,          0, 1, 32'h10,       0, 0};
    vt[18] = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 35'h0,         0, 0,   0, 35'h0,          1, 1, 32'h11,       0, 0};
    vt[19] = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 35'h14,        1, 0,   0, 35'h0,          1, 1, 32'h11,       0, 0};
    vt[20] = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 35'h0,         1, 0,   0, 35'h0,          1, 1, 32'h12,       0, 0};
    vt[21] = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 35'h0,         1, 0,   0, 35'h0,          1, 1, 32'h13,       0, 0};
    vt[22] = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 35'h0,         1, 0,   0, 35'h0,          1, 1, 32'h14,       0, 0};
    vt[23] = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 35'h0,         1, 0,   0, 35'h0,          1, 0, 32'h0,        0, 0};
    vt[24] = '{0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 35'h0,         0, 0,   0, 35'h0,          1, 0, 32'h0,        0, 1};

    do_reset();
    #1 chk_reset_outputs("reset");
    next();

    for (int i = 0; i < 25; i++) begin
      pe_x_coord_valid = vt[i].xv; pe_x_coord = vt[i].x;
      pe_y_coord_valid = vt[i].yv; pe_y_coord = vt[i].y;
      pe_message_valid = vt[i].mv; pe_message = vt[i].m;
      pe_packet_complete = vt[i].cmp; tx_flit_ready = vt[i].trdy;
      rx_flit_valid = vt[i].rv; rx_flit = vt[i].rf;
      pe_message_in_read = vt[i].rd; pe_message_in_ready = vt[i].irdy;
      #1;
      chk($sformatf("vec%0d tx_flit_valid", i), 64'(tx_flit_valid), 64'(vt[i].e_tv));
      chk($sformatf("vec%0d tx_flit", i), 64'(tx_flit), 64'(vt[i].e_tf));
      chk($sformatf("vec%0d rx_flit_ready", i), 64'(rx_flit_ready), 64'(vt[i].e_rr));
      chk($sformatf("vec%0d pe_message_in_valid", i), 64'(pe_message_in_valid), 64'(vt[i].e_iv));
      chk($sformatf("vec%0d pe_message_in", i), 64'(pe_message_in), 64'(vt[i].e_in));
      chk($sformatf("vec%0d tx_overflow", i), 64'(tx_overflow), 64'(vt[i].e_ovf));
      chk($sformatf("vec%0d proto_error", i), 64'(proto_error), 64'(vt[i].e_perr));
      next();
    end

    // Backpressure: six words plus complete into a 4-deep FIFO, dest y=1 x=0
    do_reset();
    pe_y_coord_valid = 1; pe_y_coord = 1'b1; next(); clr_inputs();
    for (int i = 0; i < 6; i++) begin
      pe_message_valid = 1; pe_message = 32'hB000_0000 + 32'(i); next(); clr_inputs();
    end
    pe_packet_complete = 1; next(); clr_inputs();
    #1;
    chk("bp tx_overflow", 64'(tx_overflow), 1);
    chk("bp proto_error", 64'(proto_error), 0);
    tx_flit_ready = 1;
    for (int i = 0; i < 4; i++) begin
      d = 32'hB000_0000 + 32'(i);
      chk($sformatf("bp drain%0d valid", i), 64'(tx_flit_valid), 1);
      chk($sformatf("bp drain%0d flit", i), 64'(tx_flit), 64'({1'b0, 1'b1, 1'b0, d}));
      next(); #1;
    end
    chk("bp drained valid", 64'(tx_flit_valid), 0);

    // Full FIFO: push and pop in the same cycle must both be taken
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pe_message_valid = 1; pe_message = 32'hC000_0000 + 32'(i); next(); clr_inputs();
    end
    #1;
    chk("full ovf before", 64'(tx_overflow), 0);
    chk("full head", 64'(tx_flit), 64'({3'b000, 32'hC000_0000}));
    tx_flit_ready = 1; pe_message_valid = 1; pe_message = 32'hC000_0005;
    next(); clr_inputs(); #1;
    chk("full ovf after", 64'(tx_overflow), 0);
    for (int i = 1; i < 5; i++) begin
      d = 32'hC000_0000 + 32'(i);
      chk($sformatf("full drain%0d valid", i), 64'(tx_flit_valid), 1);
      chk($sformatf("full drain%0d flit", i), 64'(tx_flit), 64'({3'b000, d}));
      next(); #1;
    end
    chk("full drained valid", 64'(tx_flit_valid), 0);
    pe_packet_complete = 1; next(); clr_inputs(); #1;
    chk("full close flit", 64'(tx_flit), 64'({3'b100, 32'hC000_0005}));
    chk("full close perr", 64'(proto_error), 0);

    // Protocol errors and reset recovery
    do_reset();
    pe_packet_complete = 1; next(); clr_inputs(); #1;
    chk("perr empty complete", 64'(proto_error), 1);
    chk("perr no flit", 64'(tx_flit_valid), 0);
    reset_n = 0; next(); reset_n = 1; #1;
    chk_reset_outputs("rst1");

    pe_message_valid = 1; pe_message = 32'hE000_0000; next(); clr_inputs();
    pe_message_valid = 1; pe_message = 32'hE000_0001; next(); clr_inputs(); #1;
    chk("mid flit buffered", 64'(tx_flit_valid), 1);
    reset_n = 0; next(); reset_n = 1; #1;
    chk_reset_outputs("rst2");
    pe_packet_complete = 1; next(); clr_inputs(); #1;
    chk("mid staged discarded", 64'(tx_flit_valid), 0);
    chk("mid perr", 64'(proto_error), 1);

    do_reset();
    pe_message_valid = 1; pe_message = 32'hF000_0000; next();
    pe_message = 32'hF000_0001; pe_packet_complete = 1; next(); clr_inputs(); #1;
    chk("both perr", 64'(proto_error), 1);
    chk("both flit", 64'(tx_flit), 64'({3'b000, 32'hF000_0000}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hoplite_message_interface.md
# hoplite_message_interface

Network-side endpoint for one PicoRV32 processing element on the Hoplite mesh. It sits between the PE's memory-mapped message strobes and the node's Hoplite router. On transmit, it turns coordinate, message and packet-complete strobes into single-word flits carrying a last-of-packet flag, buffered in a TX FIFO. On receive, it buffers flits from the router in an RX FIFO and presents them to the PE as a show-ahead word with a valid flag and a pop strobe.

## Interface
- COORD_BITS, 1, width of each mesh coordinate
- TX_DEPTH, 4, TX FIFO entries (power of 2, ≥2)
- RX_DEPTH, 4, RX FIFO entries (power of 2, ≥2)
- FLIT_W, 33+2*COORD_BITS, flit layout {last, dest_y, dest_x, data[31:0]}, last at MSB

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; synchronous, active-low; clock clk
- pe_x_coord / pe_x_coord_valid  in  COORD_BITS/1  destination X strobe from PE
- pe_y_coord / pe_y_coord_valid  in  COORD_BITS/1  destination Y strobe from PE
- pe_message / pe_message_valid  in  32/1  outgoing data word strobe
- pe_packet_complete  in  1  closes current packet
- pe_message_in  out  32  RX FIFO head data
- pe_message_in_valid  out  1  RX FIFO not empty
- pe_message_in_read  in  1  pop RX head
- pe_message_in_ready  in  1  pulse: PE ready to receive
- tx_flit / tx_flit_valid  out  FLIT_W/1  flit to router
- tx_flit_ready  in  1  router accepts tx_flit
- rx_flit / rx_flit_valid  in  FLIT_W/1  flit from router
- rx_flit_ready  out  1  this block accepts rx_flit
- tx_overflow  out  1  sticky: flit dropped, TX full
- proto_error  out  1  sticky: illegal strobe combination

## Operation
- Destination registers dest_x/dest_y load on the matching valid strobe. Each message captures the current dest values. A coordinate change mid-packet affects later words only.
- Staging register {stg_valid, stg_dest, stg_data} holds the newest word, because the closing strobe arrives after the last word.
- TX event rules:
  - pe_message_valid, stg_valid=0: load staging.
  - pe_message_valid, stg_valid=1: push staged flit with last=0, then load the new word into staging.
  - pe_packet_complete, stg_valid=1: push staged flit with last=1; stg_valid←0.
  - pe_packet_complete, stg_valid=0: ignored, proto_error←1.
  - pe_message_valid and pe_packet_complete in the same cycle: process the message only; set proto_error.
- TX FIFO:
  - A push is accepted if count<TX_DEPTH, or if count==TX_DEPTH and a pop occurs in the same cycle.
  - Otherwise the flit is dropped and tx_overflow←1. Staging still updates per the rules above.
  - Pop when tx_flit_valid && tx_flit_ready. tx_flit is the head (show-ahead); tx_flit_valid = count≠0.
- RX enable latch rx_en: set by the first pe_message_in_ready pulse, cleared only by reset.
- rx_flit_ready = rx_en && (rx_count<RX_DEPTH). An RX push occurs on rx_flit_valid && rx_flit_ready and stores data[31:0]; coordinates and last are discarded.
- pe_message_in is the RX head. A pe_message_in_read pulse pops one entry. A read while empty is ignored and sets proto_error.
- Pointers wrap modulo depth. Counts are $clog2(depth)+1 bits wide.

## Timing
- Reset (reset_n=0 at a clk edge): all FIFOs empty, stg_valid=0, dest_x=dest_y=0, rx_en=0, tx_flit_valid=0, tx_flit=0, rx_flit_ready=0, pe_message_in_valid=0, pe_message_in=0, tx_overflow=0, proto_error=0.
- Reset mid-packet discards staged and buffered flits.
- Strobes are single-cycle pulses, at most one strobe type per cycle in legal use.
- TX latency:
  - Word staged at edge N+1 after a strobe at N.
  - The closing strobe at M gives tx_flit_valid=1 with that flit at M+1 (if the FIFO was empty).
  - The router handshake pops at the edge where valid&&ready. The next head is visible at the following cycle.
- RX latency: accept at edge N gives pe_message_in_valid=1 at N+1. A pop at edge P advances the head at P+1.
- rx_flit_ready is combinational from registered state; it does not depend on rx_flit_valid.
- Simultaneous RX push and pop at full: rx_flit_ready=0, so only the pop happens.
- Simultaneous RX push and pop at any other count: both take effect and the count is unchanged.

## Test plan
- Basic packet: x=1, y=0, messages 0xA5A5_0001, 0xA5A5_0002, complete, tx_flit_ready=1. Required: two flits, {0,0,1,0xA5A5_0001} then {1,0,1,0xA5A5_0002}, each valid one cycle; no errors.
- Backpressure/overflow: tx_flit_ready=0, send 6 messages plus complete (TX_DEPTH=4). Required: 4 flits retained (first four data words, all last=0) and tx_overflow=1. Then raise ready: exactly 4 flits drain in order.
- Full+simultaneous: TX full, ready=1, push on the same cycle as a pop. Required: push accepted, tx_overflow stays 0, count stays 4.
- RX gating: drive rx_flit_valid with data 0x1234_5678 before any pe_message_in_ready. Required: rx_flit_ready=0. Pulse pe_message_in_ready. Required: ready=1; flit accepted; next cycle pe_message_in=0x1234_5678, valid=1; read pulse gives valid=0.
- RX full: fill 4 flits 0x10..0x13 with no reads. Required: rx_flit_ready=0. Read once: head becomes 0x11, ready returns to 1.
- Protocol errors: complete with nothing staged, then reset_n=0 for one cycle. Required: proto_error=1, then all outputs return to reset values.
